// File: rtl/synth_config_writer.sv
// synth_config_writer: turns 4-byte host packets (OPCODE, ADDR, DATA_HI, DATA_LO)
// into envelope / note-on config write strobes, including an all-voices broadcast.
// Latency: strobe appears the cycle after DATA_LO is accepted; a broadcast runs N cycles.
// Backpressure: o_RxReady drops during WRITE/BROADCAST and while i_Reset is high.
// Ports:
//   i_Clock, i_Reset                 clock, synchronous active-high reset
//   i_RxByte, i_RxValid, o_RxReady   byte stream from the host link (valid/ready)
//   o_EnvelopeConfigWriteEnable[4:0] one-hot: attack lvl, sustain lvl, attack/decay/release rate
//   o_NoteOnConfigWriteEnable[1:0]   bit 1 -> note-on[31:16], bit 0 -> note-on[15:0]
//   o_ConfigWriteAddr, o_ConfigWriteData  write address / data (held between strobes)
//   o_Busy, o_ErrorCount             activity flag, saturating count of rejected packets
module synth_config_writer #(
  parameter int NUM_VOICE_OPERATORS = 256,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [7:0]  i_RxByte,
  input  logic        i_RxValid,
  output logic        o_RxReady,
  output logic [4:0]  o_EnvelopeConfigWriteEnable,
  output logic [1:0]  o_NoteOnConfigWriteEnable,
  output logic [7:0]  o_ConfigWriteAddr,
  output logic [15:0] o_ConfigWriteData,
  output logic        o_Busy,
  output logic [7:0]  o_ErrorCount
);

  localparam int         CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] LAST_OP  = 8'(NUM_VOICE_OPERATORS - 1);
  localparam logic [CW-1:0] GAP_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_HI, S_GET_LO, S_WRITE, S_BROADCAST
  } state_t;

  // Opcode is decoded once on acceptance so only the useful fields are kept.
  typedef enum logic [1:0] { K_ENV, K_NOTE, K_BCAST } kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    addr_byte_q, addr_byte_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [4:0]    env_we_q, env_we_d;
  logic [1:0]    note_we_q, note_we_d;
  logic [7:0]    waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [7:0]    err_q, err_d;
  logic          busy_q, rdy_q;
  logic          accept;

  // Ready is a registered state decode, forced low while reset is held.
  assign o_RxReady = rdy_q & ~i_Reset;
  assign accept    = i_RxValid & o_RxReady;

  assign o_EnvelopeConfigWriteEnable = env_we_q;
  assign o_NoteOnConfigWriteEnable   = note_we_q;
  assign o_ConfigWriteAddr           = waddr_q;
  assign o_ConfigWriteData           = wdata_q;
  assign o_Busy                      = busy_q;
  assign o_ErrorCount                = err_q;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    sel_d       = sel_q;
    addr_byte_d = addr_byte_q;
    hi_d        = hi_q;
    gap_d       = gap_q;
    env_we_d    = '0;
    note_we_d   = '0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (accept) begin
          sel_d = i_RxByte[2:0];
          if (i_RxByte <= 8'h04) begin
            kind_d  = K_ENV;
            state_d = S_GET_ADDR;
          end else if (i_RxByte == 8'h10 || i_RxByte == 8'h11) begin
            kind_d  = K_NOTE;
            state_d = S_GET_ADDR;
          end else if (i_RxByte >= 8'h20 && i_RxByte <= 8'h24) begin
            kind_d  = K_BCAST;
            state_d = S_GET_ADDR;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end

      S_GET_ADDR, S_GET_HI, S_GET_LO: begin
        if (accept) begin
          // A byte arriving on the final gap cycle still counts; no timeout.
          gap_d = '0;
          if (state_q == S_GET_ADDR) begin
            addr_byte_d = i_RxByte;
            state_d     = S_GET_HI;
          end else if (state_q == S_GET_HI) begin
            hi_d    = i_RxByte;
            state_d = S_GET_LO;
          end else begin
            wdata_d = {hi_q, i_RxByte};
            case (kind_q)
              K_BCAST: begin
                env_we_d = 5'(5'b00001 << sel_q);
                waddr_d  = 8'h00;
                state_d  = S_BROADCAST;
              end
              K_NOTE: begin
                note_we_d = sel_q[0] ? 2'b10 : 2'b01;
                state_d   = S_WRITE;
              end
              default: begin
                env_we_d = 5'(5'b00001 << sel_q);
                waddr_d  = addr_byte_q;
                state_d  = S_WRITE;
              end
            endcase
          end
        end else if (gap_q == GAP_LIMIT) begin
          gap_d   = '0;
          state_d = S_IDLE;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_WRITE: state_d = S_IDLE;

      S_BROADCAST: begin
        if (waddr_q == LAST_OP) begin
          state_d = S_IDLE;
        end else begin
          env_we_d = env_we_q;
          waddr_d  = waddr_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_ENV;
      sel_q       <= '0;
      addr_byte_q <= '0;
      hi_q        <= '0;
      gap_q       <= '0;
      env_we_q    <= '0;
      note_we_q   <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      sel_q       <= sel_d;
      addr_byte_q <= addr_byte_d;
      hi_q        <= hi_d;
      gap_q       <= gap_d;
      env_we_q    <= env_we_d;
      note_we_q   <= note_we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      rdy_q       <= (state_d != S_WRITE) && (state_d != S_BROADCAST);
    end
  end

endmodule

// File: tb/tb_synth_config_writer.sv
module tb_synth_config_writer;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [7:0]  i_RxByte;
  logic        i_RxValid;
  logic        o_RxReady;
  logic [4:0]  o_EnvelopeConfigWriteEnable;
  logic [1:0]  o_NoteOnConfigWriteEnable;
  logic [7:0]  o_ConfigWriteAddr;
  logic [15:0] o_ConfigWriteData;
  logic        o_Busy;
  logic [7:0]  o_ErrorCount;

  int total = 0;
  int bad   = 0;

  // Reference state: what the outputs should hold between strobes.
  logic [7:0]  m_err;
  logic [7:0]  m_addr;
  logic [15:0] m_data;

  synth_config_writer #(.NUM_VOICE_OPERATORS(256), .TIMEOUT_CYCLES(1024)) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_RxByte(i_RxByte),
    .i_RxValid(i_RxValid),
    .o_RxReady(o_RxReady),
    .o_EnvelopeConfigWriteEnable(o_EnvelopeConfigWriteEnable),
    .o_NoteOnConfigWriteEnable(o_NoteOnConfigWriteEnable),
    .o_ConfigWriteAddr(o_ConfigWriteAddr),
    .o_ConfigWriteData(o_ConfigWriteData),
    .o_Busy(o_Busy),
    .o_ErrorCount(o_ErrorCount)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    i_RxValid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RxValid = 1'b1;
    i_RxByte  = b;
    chk("rx_ready_before_byte", o_RxReady, 1);
    step();
    i_RxValid = 1'b0;
    i_RxByte  = 8'($urandom);
  endtask

  function automatic bit op_ok(input logic [7:0] op);
    return (op <= 8'h04) || (op == 8'h10) || (op == 8'h11) ||
           (op >= 8'h20 && op <= 8'h24);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_env"},  o_EnvelopeConfigWriteEnable, 0);
    chk({tag, "_note"}, o_NoteOnConfigWriteEnable, 0);
    chk({tag, "_busy"}, o_Busy, 0);
    chk({tag, "_rdy"},  o_RxReady, 1);
    chk({tag, "_err"},  o_ErrorCount, m_err);
    chk({tag, "_addr"}, o_ConfigWriteAddr, m_addr);
    chk({tag, "_data"}, o_ConfigWriteData, m_data);
  endtask

  // Called right after DATA_LO was accepted: checks the whole issue phase.
  task automatic chk_issue(input logic [7:0] op, input logic [7:0] a, input logic [15:0] d);
    m_data = d;
    if (op <= 8'h04) begin
      m_addr = a;
      chk("env_strobe", o_EnvelopeConfigWriteEnable, 32'd1 << op);
      chk("env_note0",  o_NoteOnConfigWriteEnable, 0);
      chk("env_addr",   o_ConfigWriteAddr, m_addr);
      chk("env_data",   o_ConfigWriteData, d);
      chk("env_rdy",    o_RxReady, 0);
      chk("env_busy",   o_Busy, 1);
      step();
    end else if (op == 8'h10 || op == 8'h11) begin
      chk("note_strobe", o_NoteOnConfigWriteEnable, (op == 8'h11) ? 2 : 1);
      chk("note_env0",   o_EnvelopeConfigWriteEnable, 0);
      chk("note_data",   o_ConfigWriteData, d);
      chk("note_rdy",    o_RxReady, 0);
      step();
    end else begin
      for (int i = 0; i < 256; i++) begin
        chk("bc_strobe", o_EnvelopeConfigWriteEnable, 32'd1 << (op - 8'h20));
        chk("bc_addr",   o_ConfigWriteAddr, i);
        chk("bc_data",   o_ConfigWriteData, d);
        chk("bc_rdy",    o_RxReady, 0);
        chk("bc_busy",   o_Busy, 1);
        step();
      end
      m_addr = 8'hFF;
    end
    chk_quiet("after_issue");
  endtask

  task automatic run_packet(input logic [7:0] op, input logic [7:0] a,
                            input logic [15:0] d, input int max_gap);
    send_byte(op);
    if (!op_ok(op)) begin
      m_err = sat_inc(m_err);
      chk_quiet("bad_op");
    end else begin
      idle($urandom_range(0, max_gap));
      send_byte(a);
      idle($urandom_range(0, max_gap));
      send_byte(d[15:8]);
      idle($urandom_range(0, max_gap));
      send_byte(d[7:0]);
      chk_issue(op, a, d);
    end
  endtask

  initial begin
    logic [7:0] op;
    logic [7:0] good_ops [12];
    good_ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11,
                 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    i_Reset = 1'b1; i_RxValid = 1'b0; i_RxByte = 8'h00;
    m_err = 0; m_addr = 0; m_data = 0;

    // Reset state
    repeat (3) step();
    chk("rst_rdy_low", o_RxReady, 0);
    chk("rst_env", o_EnvelopeConfigWriteEnable, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_err", o_ErrorCount, 0);
    i_Reset = 1'b0;
    step();
    chk_quiet("post_reset");

    // Directed packets
    run_packet(8'h02, 8'h07, 16'h0ABC, 0);
    run_packet(8'h11, 8'hFF, 16'h1234, 0);
    run_packet(8'h21, 8'h00, 16'h3FFF, 0);
    run_packet(8'h05, 8'h00, 16'h0000, 0);

    // Timeout: 1023 idle cycles keep the packet, the 1024th discards it
    send_byte(8'h00);
    send_byte(8'h03);
    idle(1023);
    chk("to_pending_busy", o_Busy, 1);
    chk("to_pending_err", o_ErrorCount, m_err);
    step();
    m_err = sat_inc(m_err);
    chk_quiet("to_fired");
    run_packet(8'h04, 8'h9A, 16'hBEEF, 0);

    // A byte on the last gap cycle wins over the timeout
    send_byte(8'h01);
    send_byte(8'h05);
    idle(1023);
    send_byte(8'h12);
    send_byte(8'h34);
    chk_issue(8'h01, 8'h05, 16'h1234);

    // Randomized packets, mixing valid and arbitrary opcodes
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = good_ops[$urandom_range(0, 11)];
      run_packet(op, 8'($urandom), 16'($urandom), 3);
    end

    // Error counter saturation
    while (m_err != 8'hFF) run_packet(8'h05 + 8'($urandom_range(0, 10)), 0, 0, 0);
    for (int n = 0; n < 4; n++) run_packet(8'hF0, 0, 0, 0);
    chk("err_saturated", o_ErrorCount, 255);

    // Reset in the middle of a broadcast
    send_byte(8'h23);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'hAA);
    for (int i = 0; i < 8'h40; i++) step();
    chk("bc_mid_addr", o_ConfigWriteAddr, 8'h40);
    chk("bc_mid_strobe", o_EnvelopeConfigWriteEnable, 5'b01000);
    i_Reset = 1'b1;
    #1;
    chk("rst_mid_rdy", o_RxReady, 0);
    step();
    chk("rst_mid_env", o_EnvelopeConfigWriteEnable, 0);
    chk("rst_mid_busy", o_Busy, 0);
    chk("rst_mid_err", o_ErrorCount, 0);
    chk("rst_mid_addr", o_ConfigWriteAddr, 0);
    step();
    chk("rst_mid_env2", o_EnvelopeConfigWriteEnable, 0);
    i_Reset = 1'b0;
    m_err = 0; m_addr = 0; m_data = 0;
    step();
    chk_quiet("after_mid_reset");
    run_packet(8'h00, 8'h33, 16'hC0DE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
